// File: rtl/synth_voice_pkg.sv
// Shared types for the polyphonic voice allocator: FSM states, scan target
// classes and the velocity substituted when a note-on arrives with velocity 0.
package synth_voice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ISSUE
  } state_e;

  typedef enum logic [2:0] {
    T_MATCH,
    T_FREE,
    T_REL,
    T_HELD,
    T_NONE
  } tsel_e;

  localparam logic [6:0] VEL_OFF_DEFAULT = 7'd64;

endpackage

// File: rtl/voice_alloc_if.sv
// Note request channel between the MIDI decoder (master) and the voice
// allocator (slave); a transfer happens on any edge with req_valid & req_ready.
interface voice_alloc_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_on;
  logic [6:0] req_key;
  logic [6:0] req_vel;

  modport master (
    output req_valid,
    output req_on,
    output req_key,
    output req_vel,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_on,
    input  req_key,
    input  req_vel,
    output req_ready
  );

endinterface

// File: rtl/voice_lru_rank.sv
// Least-recently-used rank per voice: 0 = most recent, VOICES-1 = oldest.
// A touch moves the voice to rank 0 and ages every voice that was younger.
module voice_lru_rank #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             touch_i,
  input  logic [V_WIDTH-1:0]               touch_idx_i,
  output logic [VOICES-1:0][V_WIDTH-1:0]   rank_o
);

  logic [VOICES-1:0][V_WIDTH-1:0] rank_q;
  logic [V_WIDTH-1:0]             touched_rank;

  assign touched_rank = rank_q[touch_idx_i];
  assign rank_o       = rank_q;

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_rank
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rank_q[gi] <= V_WIDTH'(gi);
      end else if (touch_i) begin
        if (touch_idx_i == V_WIDTH'(gi)) begin
          rank_q[gi] <= '0;
        end else if (rank_q[gi] < touched_rank) begin
          rank_q[gi] <= rank_q[gi] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans one voice per cycle, then issues a note
// event to the synth engine. Optional sustain pedal via VOICE_ALLOC_SUSTAIN_EN.
module voice_alloc
  import synth_voice_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               OSC_CLK,
  input  logic               iRST,
  voice_alloc_if.slave       req,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic               sustain,
`endif
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off
);

  state_e                     state_q, state_d;
  logic [V_WIDTH-1:0]         idx_q, idx_d;
  logic                       ev_on_q, ev_on_d;
  logic [6:0]                 ev_key_q, ev_key_d;
  logic [6:0]                 ev_vel_q, ev_vel_d;
  logic                       match_fnd_q, match_fnd_d;
  logic                       free_fnd_q, free_fnd_d;
  logic                       rel_fnd_q, rel_fnd_d;
  logic                       held_fnd_q, held_fnd_d;
  logic [V_WIDTH-1:0]         match_idx_q, match_idx_d;
  logic [V_WIDTH-1:0]         free_idx_q, free_idx_d;
  logic [V_WIDTH-1:0]         rel_idx_q, rel_idx_d;
  logic [V_WIDTH-1:0]         held_idx_q, held_idx_d;
  logic [V_WIDTH-1:0]         rel_rank_q, rel_rank_d;
  logic [V_WIDTH-1:0]         held_rank_q, held_rank_d;
  logic [VOICES-1:0][6:0]     key_tab_q, key_tab_d;
  logic [VOICES-1:0]          keys_on_q, keys_on_d;
  logic                       note_on_q, note_on_d;
  logic [V_WIDTH-1:0]         cur_adr_q, cur_adr_d;
  logic [7:0]                 cur_key_q, cur_key_d;
  logic [7:0]                 vel_on_q, vel_on_d;
  logic [7:0]                 vel_off_q, vel_off_d;

  logic [VOICES-1:0][V_WIDTH-1:0] rank;
  logic                       touch;
  tsel_e                      tsel;
  logic [V_WIDTH-1:0]         tgt_idx;
  logic                       hold_off;
  logic                       scan_kon;
  logic                       scan_vf;
  logic [V_WIDTH-1:0]         scan_rank;

`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic [VOICES-1:0]          sus_q, sus_d;
  logic                       sus_lvl_q, sus_lvl_d;
  logic                       rel_pend_q, rel_pend_d;
  assign hold_off = rel_pend_q;
`else
  assign hold_off = 1'b0;
`endif

  voice_lru_rank #(
    .VOICES  (VOICES),
    .V_WIDTH (V_WIDTH)
  ) u_lru (
    .clk         (OSC_CLK),
    .rst         (iRST),
    .touch_i     (touch),
    .touch_idx_i (tgt_idx),
    .rank_o      (rank)
  );

  assign req.req_ready = (state_q == IDLE) && !hold_off;
  assign keys_on       = keys_on_q;
  assign note_on       = note_on_q;
  assign cur_key_adr   = cur_adr_q;
  assign cur_key_val   = cur_key_q;
  assign cur_vel_on    = vel_on_q;
  assign cur_vel_off   = vel_off_q;

  assign scan_kon  = keys_on_q[idx_q];
  assign scan_vf   = voice_free[idx_q];
  assign scan_rank = rank[idx_q];

  // Note-on priority: retrigger > free > released (oldest) > held (oldest).
  always_comb begin
    tsel    = T_NONE;
    tgt_idx = '0;
    if (match_fnd_q) begin
      tsel    = T_MATCH;
      tgt_idx = match_idx_q;
    end else if (ev_on_q) begin
      if (free_fnd_q) begin
        tsel    = T_FREE;
        tgt_idx = free_idx_q;
      end else if (rel_fnd_q) begin
        tsel    = T_REL;
        tgt_idx = rel_idx_q;
      end else if (held_fnd_q) begin
        tsel    = T_HELD;
        tgt_idx = held_idx_q;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ev_on_d     = ev_on_q;
    ev_key_d    = ev_key_q;
    ev_vel_d    = ev_vel_q;
    match_fnd_d = match_fnd_q;
    free_fnd_d  = free_fnd_q;
    rel_fnd_d   = rel_fnd_q;
    held_fnd_d  = held_fnd_q;
    match_idx_d = match_idx_q;
    free_idx_d  = free_idx_q;
    rel_idx_d   = rel_idx_q;
    held_idx_d  = held_idx_q;
    rel_rank_d  = rel_rank_q;
    held_rank_d = held_rank_q;
    key_tab_d   = key_tab_q;
    keys_on_d   = keys_on_q;
    note_on_d   = 1'b0;
    cur_adr_d   = cur_adr_q;
    cur_key_d   = cur_key_q;
    vel_on_d    = vel_on_q;
    vel_off_d   = vel_off_q;
    touch       = 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    sus_d       = sus_q;
    sus_lvl_d   = sustain;
    rel_pend_d  = rel_pend_q | (sus_lvl_q & ~sustain);
`endif

    unique case (state_q)
      IDLE: begin
        if (hold_off) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
          keys_on_d  = keys_on_q & ~sus_q;
          sus_d      = '0;
          rel_pend_d = sus_lvl_q & ~sustain;
`endif
        end else if (req.req_valid) begin
          // A zero-velocity note-on is a note-off in MIDI running-status style.
          ev_on_d     = req.req_on && (req.req_vel != 7'd0);
          ev_key_d    = req.req_key;
          ev_vel_d    = (req.req_on && (req.req_vel == 7'd0)) ? VEL_OFF_DEFAULT : req.req_vel;
          match_fnd_d = 1'b0;
          free_fnd_d  = 1'b0;
          rel_fnd_d   = 1'b0;
          held_fnd_d  = 1'b0;
          idx_d       = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (scan_kon && (key_tab_q[idx_q] == ev_key_q) && !match_fnd_q) begin
          match_fnd_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!scan_kon && scan_vf && !free_fnd_q) begin
          free_fnd_d = 1'b1;
          free_idx_d = idx_q;
        end
        if (!scan_kon && !scan_vf && (!rel_fnd_q || (scan_rank > rel_rank_q))) begin
          rel_fnd_d  = 1'b1;
          rel_idx_d  = idx_q;
          rel_rank_d = scan_rank;
        end
        if (scan_kon && (!held_fnd_q || (scan_rank > held_rank_q))) begin
          held_fnd_d  = 1'b1;
          held_idx_d  = idx_q;
          held_rank_d = scan_rank;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == V_WIDTH'(VOICES - 1)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = IDLE;
        if (tsel != T_NONE) begin
          cur_adr_d = tgt_idx;
          cur_key_d = {1'b0, ev_key_q};
          if (ev_on_q) begin
            keys_on_d[tgt_idx] = 1'b1;
            key_tab_d[tgt_idx] = ev_key_q;
            vel_on_d           = {1'b0, ev_vel_q};
            note_on_d          = 1'b1;
            touch              = 1'b1;
`ifdef VOICE_ALLOC_SUSTAIN_EN
            sus_d[tgt_idx]     = 1'b0;
`endif
          end else begin
            vel_off_d = {1'b0, ev_vel_q};
`ifdef VOICE_ALLOC_SUSTAIN_EN
            if (sus_lvl_q) begin
              sus_d[tgt_idx] = 1'b1;
            end else begin
              keys_on_d[tgt_idx] = 1'b0;
            end
`else
            keys_on_d[tgt_idx] = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ev_on_q     <= 1'b0;
      ev_key_q    <= '0;
      ev_vel_q    <= '0;
      match_fnd_q <= 1'b0;
      free_fnd_q  <= 1'b0;
      rel_fnd_q   <= 1'b0;
      held_fnd_q  <= 1'b0;
      match_idx_q <= '0;
      free_idx_q  <= '0;
      rel_idx_q   <= '0;
      held_idx_q  <= '0;
      rel_rank_q  <= '0;
      held_rank_q <= '0;
      key_tab_q   <= '0;
      keys_on_q   <= '0;
      note_on_q   <= 1'b0;
      cur_adr_q   <= '0;
      cur_key_q   <= '0;
      vel_on_q    <= '0;
      vel_off_q   <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      sus_q       <= '0;
      sus_lvl_q   <= 1'b0;
      rel_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ev_on_q     <= ev_on_d;
      ev_key_q    <= ev_key_d;
      ev_vel_q    <= ev_vel_d;
      match_fnd_q <= match_fnd_d;
      free_fnd_q  <= free_fnd_d;
      rel_fnd_q   <= rel_fnd_d;
      held_fnd_q  <= held_fnd_d;
      match_idx_q <= match_idx_d;
      free_idx_q  <= free_idx_d;
      rel_idx_q   <= rel_idx_d;
      held_idx_q  <= held_idx_d;
      rel_rank_q  <= rel_rank_d;
      held_rank_q <= held_rank_d;
      key_tab_q   <= key_tab_d;
      keys_on_q   <= keys_on_d;
      note_on_q   <= note_on_d;
      cur_adr_q   <= cur_adr_d;
      cur_key_q   <= cur_key_d;
      vel_on_q    <= vel_on_d;
      vel_off_q   <= vel_off_d;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      sus_q       <= sus_d;
      sus_lvl_q   <= sus_lvl_d;
      rel_pend_q  <= rel_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: allocation, LRU stealing, retrigger, note-off
// drop and zero-velocity handling; sustain cases when VOICE_ALLOC_SUSTAIN_EN is set.
module tb_voice_alloc;

  localparam int VOICES  = 8;
  localparam int V_WIDTH = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [VOICES-1:0]  voice_free;
  logic [VOICES-1:0]  keys_on;
  logic               note_on;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val;
  logic [7:0]         cur_vel_on;
  logic [7:0]         cur_vel_off;
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic               sustain;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  logic pre_note_on;

  always #5 clk = ~clk;

  voice_alloc_if rif ();

  voice_alloc #(
    .VOICES  (VOICES),
    .V_WIDTH (V_WIDTH)
  ) dut (
    .OSC_CLK     (clk),
    .iRST        (rst),
    .req         (rif),
`ifdef VOICE_ALLOC_SUSTAIN_EN
    .sustain     (sustain),
`endif
    .voice_free  (voice_free),
    .keys_on     (keys_on),
    .note_on     (note_on),
    .cur_key_adr (cur_key_adr),
    .cur_key_val (cur_key_val),
    .cur_vel_on  (cur_vel_on),
    .cur_vel_off (cur_vel_off)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    rif.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One transfer, then wait to just after the output-update edge (VOICES+1 edges on).
  task automatic send(input logic on, input logic [6:0] key, input logic [6:0] vel);
    int w;
    w = 0;
    @(negedge clk);
    while (!rif.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!rif.req_ready) check("ready_timeout", 32'(rif.req_ready), 32'd1);
    rif.req_valid = 1'b1;
    rif.req_on    = on;
    rif.req_key   = key;
    rif.req_vel   = vel;
    @(posedge clk);
    #1;
    rif.req_valid = 1'b0;
    check("busy_ready", 32'(rif.req_ready), 32'd0);
    repeat (VOICES) @(posedge clk);
    #1;
    pre_note_on = note_on;
    @(posedge clk);
    #1;
    $display("EVT on=%0d key=%0d vel=%0d -> adr=%0d keys_on=%02h note_on=%0d key_val=%0d vel_on=%0d vel_off=%0d",
             on, key, vel, cur_key_adr, keys_on, note_on, cur_key_val, cur_vel_on, cur_vel_off);
  endtask

  initial begin
    rst           = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_on    = 1'b0;
    rif.req_key   = '0;
    rif.req_vel   = '0;
    voice_free    = 8'hFF;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    sustain       = 1'b0;
`endif
    apply_reset();
    #1;
    check("rst_keys_on", 32'(keys_on), 32'h00);
    check("rst_note_on", 32'(note_on), 32'd0);
    check("rst_adr", 32'(cur_key_adr), 32'd0);
    check("rst_key_val", 32'(cur_key_val), 32'd0);
    check("rst_vel_on", 32'(cur_vel_on), 32'd0);
    check("rst_vel_off", 32'(cur_vel_off), 32'd0);
    check("rst_ready", 32'(rif.req_ready), 32'd1);

    // First note lands on voice 0 exactly VOICES+1 edges after the transfer.
    send(1'b1, 7'd60, 7'd100);
    check("t1_latency", 32'(pre_note_on), 32'd0);
    check("t1_note_on", 32'(note_on), 32'd1);
    check("t1_adr", 32'(cur_key_adr), 32'd0);
    check("t1_keys_on", 32'(keys_on), 32'h01);
    check("t1_key_val", 32'(cur_key_val), 32'd60);
    check("t1_vel_on", 32'(cur_vel_on), 32'd100);
    @(posedge clk);
    #1;
    check("t1_pulse_end", 32'(note_on), 32'd0);

    // Fill remaining voices, then steal the oldest held voice.
    for (int k = 61; k <= 67; k++) begin
      send(1'b1, 7'(k), 7'd80);
      check("t2_fill_adr", 32'(cur_key_adr), 32'(k - 60));
    end
    check("t2_full", 32'(keys_on), 32'hFF);
    voice_free = 8'h00;
    send(1'b1, 7'd70, 7'd90);
    check("t2_steal_adr", 32'(cur_key_adr), 32'd0);
    check("t2_steal_keys", 32'(keys_on), 32'hFF);
    check("t2_steal_key_val", 32'(cur_key_val), 32'd70);
    check("t2_steal_note_on", 32'(note_on), 32'd1);

    // Note-off, then free voice beats released voice.
    apply_reset();
    voice_free = 8'hFF;
    send(1'b1, 7'd60, 7'd100);
    voice_free = 8'hFE;
    send(1'b0, 7'd60, 7'd40);
    check("t3_off_keys", 32'(keys_on), 32'h00);
    check("t3_off_adr", 32'(cur_key_adr), 32'd0);
    check("t3_off_vel", 32'(cur_vel_off), 32'd40);
    check("t3_off_note_on", 32'(note_on), 32'd0);
    check("t3_off_vel_on", 32'(cur_vel_on), 32'd100);
    send(1'b1, 7'd62, 7'd80);
    check("t3_free_adr", 32'(cur_key_adr), 32'd1);
    check("t3_free_keys", 32'(keys_on), 32'h02);
    check("t3_free_vel_on", 32'(cur_vel_on), 32'd80);

    // Duplicate note-on retriggers, unmatched off is dropped, vel-0 on is an off.
    apply_reset();
    voice_free = 8'hFF;
    send(1'b1, 7'd60, 7'd100);
    send(1'b1, 7'd60, 7'd100);
    check("t4_retrig_pulse", 32'(note_on), 32'd1);
    check("t4_retrig_adr", 32'(cur_key_adr), 32'd0);
    check("t4_retrig_keys", 32'(keys_on), 32'h01);
    send(1'b0, 7'd61, 7'd30);
    check("t4_drop_keys", 32'(keys_on), 32'h01);
    check("t4_drop_key_val", 32'(cur_key_val), 32'd60);
    check("t4_drop_vel_off", 32'(cur_vel_off), 32'd0);
    send(1'b1, 7'd60, 7'd0);
    check("t5_vel0_keys", 32'(keys_on), 32'h00);
    check("t5_vel0_vel_off", 32'(cur_vel_off), 32'd64);
    check("t5_vel0_note_on", 32'(note_on), 32'd0);
    check("t5_vel0_vel_on", 32'(cur_vel_on), 32'd100);

`ifdef VOICE_ALLOC_SUSTAIN_EN
    apply_reset();
    voice_free = 8'hFF;
    sustain    = 1'b1;
    send(1'b1, 7'd60, 7'd100);
    send(1'b0, 7'd60, 7'd50);
    check("sus_held_keys", 32'(keys_on), 32'h01);
    check("sus_vel_off", 32'(cur_vel_off), 32'd50);
    @(negedge clk);
    sustain = 1'b0;
    @(posedge clk);
    #1;
    check("sus_rel_ready", 32'(rif.req_ready), 32'd0);
    check("sus_rel_keys_pre", 32'(keys_on), 32'h01);
    @(posedge clk);
    #1;
    check("sus_rel_keys", 32'(keys_on), 32'h00);
    check("sus_rel_ready_back", 32'(rif.req_ready), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Polyphonic voice allocator and scheduler in front of synth_engine.
- Accepts decoded MIDI note-on/note-off requests over a valid/ready handshake and maps each onto one of VOICES voice slots.
- Drives the engine's keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on and cur_vel_off inputs.
- Uses voice_free from the envelope generator, with LRU stealing when no slot is free.

Parameters:
- VOICES, 8: number of voice slots; power of two.
- V_WIDTH, 3: log2(VOICES); width of voice address and LRU rank.

Ports:
- OSC_CLK  in  1  single clock; all state on rising edge.
- iRST  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  allocator can accept a request.
- req_on  in  1  1 = note-on, 0 = note-off.
- req_key  in  7  MIDI key number.
- req_vel  in  7  MIDI velocity.
- voice_free  in  VOICES  per-voice envelope idle flag from env gen.
- keys_on  out  VOICES  per-voice gate.
- note_on  out  1  one-cycle pulse, new voice assignment.
- cur_key_adr  out  V_WIDTH  voice addressed by the last event.
- cur_key_val  out  8  {1'b0, key} of the last event.
- cur_vel_on  out  8  {1'b0, vel} of the last note-on.
- cur_vel_off  out  8  {1'b0, vel} of the last note-off.

Behaviour:
- Reset values:
  - keys_on=0, note_on=0, cur_*=0, req_ready=1, state=IDLE.
  - Key table cleared; rank[i]=i.
  - Reset mid-scan aborts the event with no output change.
- Handshake:
  - A transfer occurs on any edge where req_valid and req_ready are both 1.
  - req_ready=1 only in IDLE.
  - Request fields are captured on transfer.
  - A note-on with vel=0 is converted to a note-off with vel 64.
- FSM IDLE -> SCAN -> ISSUE -> IDLE:
  - SCAN lasts exactly VOICES cycles and evaluates voice i on scan cycle i.
  - ISSUE lasts 1 cycle.
  - Fixed latency: transfer to output update is VOICES+1 cycles.
  - req_ready returns to 1 the cycle after ISSUE.
- SCAN bookkeeping:
  - match: first i with keys_on[i]=1 and key[i]=req_key.
  - free: lowest i with voice_free[i]=1 and keys_on[i]=0.
  - rel: max rank among keys_on=0 and voice_free=0 (released, still decaying).
  - held: max rank among keys_on=1.
  - Rank ties cannot occur: ranks are always a permutation of 0..VOICES-1.
- Note-on target priority: match (retrigger) > free > rel > held (steal).
- Note-on ISSUE:
  - keys_on[t]=1, key[t]=req_key, cur_key_adr=t, cur_key_val and cur_vel_on updated, note_on=1 for this cycle only.
  - LRU update: rank[t]=0; every rank below the old rank[t] is incremented.
  - When stealing a held voice, no extra off event is issued; the gate simply stays high with the new key.
- Note-off ISSUE:
  - If a match exists: keys_on[t]=0, cur_key_adr=t, cur_key_val and cur_vel_off updated, note_on stays 0, ranks unchanged.
  - No match: event dropped, no output change.
- voice_free is sampled during SCAN only; changes during ISSUE are ignored until the next event.
- Duplicate note-on for a held key retriggers the same voice and never takes a second slot.

Optional Feature:
- Macro: VOICE_ALLOC_SUSTAIN_EN.
- With the macro defined:
  - Adds input sustain (1 bit, MIDI CC64 >= 64).
  - While sustain=1, a matched note-off sets sus[t] instead of clearing keys_on; cur_vel_off is still updated.
  - Falling edge of sustain: in one cycle, clear keys_on for all voices with sus=1, then clear sus.
  - req_ready=0 during that cycle.
  - A note-on retrigger of a voice clears its sus bit.
- Without the macro: no sustain port; note-off always clears the gate.

Decomposition:
- Package synth_voice_pkg:
  - FSM state enum {IDLE, SCAN, ISSUE}.
  - Target-select enum {T_MATCH, T_FREE, T_REL, T_HELD, T_NONE}.
  - Constant default velocity-off value 64.
- Sub-module voice_lru_rank:
  - Holds the rank array.
  - Inputs: touch strobe and touch index.
  - Outputs: rank[i] for the scan comparator.
  - Reset permutation is rank[i]=i.

Test Plan:
- Reset then on(60,100) with voice_free=8'hFF -> after 9 cycles: note_on pulse, cur_key_adr=0, keys_on=8'h01, cur_key_val=60, cur_vel_on=100.
- on keys 60..67, then on(70,90) with voice_free=0 -> steals voice 0 (oldest held); keys_on stays 8'hFF, cur_key_adr=0, cur_key_val=70.
- on(60), off(60,40) with voice_free[0]=0, then on(62) with voice_free=8'hFE -> off clears keys_on[0] and sets cur_vel_off=40; next on goes to voice 1 (free beats released).
- on(60,100) twice -> both events use voice 0, keys_on=8'h01, two note_on pulses; off(61) -> no output change.
- on(60,0) while voice 0 holds 60 -> treated as off: keys_on[0]=0, cur_vel_off=64.
- With VOICE_ALLOC_SUSTAIN_EN: sustain=1, on(60), off(60) -> keys_on[0] stays 1; sustain 1->0 -> keys_on[0]=0 one cycle later, req_ready low for that cycle.
